// File: rtl/apb_pkg.sv
// Shared types and widths for the APB storage slave.
package apb_pkg;

  localparam int APB_ADDR_W = 9;
  localparam int APB_DATA_W = 8;
  localparam int APB_WCNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_slave_if.sv
// APB bus bundle between one master and the storage slave.
interface apb_slave_if;
  import apb_pkg::*;

  logic                  PSEL;
  logic                  PEN;
  logic                  PWRITE;
  logic [APB_ADDR_W-1:0] PADDR;
  logic [APB_DATA_W-1:0] PWDATA;
  logic [APB_DATA_W-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PEN, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PEN, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_slave_mem.sv
// DEPTH x 8 storage: synchronous write, asynchronous read, synchronous clear.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [APB_DATA_W-1:0] wdata_i,
  output logic [APB_DATA_W-1:0] rdata_o
);

  logic [APB_DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/apb_slave.sv
// APB slave with wait-state insertion over a small byte store.
// Optional error response enabled by defining APB_SLAVE_ERR_EN.
//
// state | meaning
// IDLE  | waiting for a setup phase (PSEL=1, PEN=0)
// WAIT  | access phase, PREADY low, counting wait cycles
// DONE  | PREADY high for one cycle, write commits at its end
module apb_slave
  import apb_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  apb_slave_if.slave  bus
);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_WAIT = ST_WAIT;
  localparam logic [1:0] S_DONE = ST_DONE;

  localparam int                    MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [APB_WCNT_W-1:0] WAIT_N  = APB_WCNT_W'(WAIT_CYCLES);
  localparam logic [APB_WCNT_W-1:0] CNT_ONE = APB_WCNT_W'(1);

  logic [1:0]            state_q, state_d;
  logic [APB_WCNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]            addr_q, addr_d;
  logic                  wr_q, wr_d;
  logic [APB_DATA_W-1:0] wdata_q, wdata_d;

  logic                  setup;
  logic                  done;
  logic                  in_range;
  logic                  mem_we;
  logic [APB_DATA_W-1:0] mem_rdata;
  logic                  unused_paddr_msb;

  assign setup            = bus.PSEL & ~bus.PEN;
  assign done             = (state_q == S_DONE);
  assign in_range         = ({1'b0, addr_q} < 9'(DEPTH));
  assign unused_paddr_msb = bus.PADDR[APB_ADDR_W-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          addr_d  = bus.PADDR[7:0];
          wr_d    = bus.PWRITE;
          wdata_d = bus.PWDATA;
          cnt_d   = '0;
          state_d = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        // Losing PSEL mid-wait abandons the transfer without a write.
        if (!bus.PSEL) begin
          state_d = S_IDLE;
        end else if (bus.PEN) begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_d == WAIT_N) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_we = done & wr_q & in_range;

  apb_slave_mem #(
    .DEPTH (DEPTH),
    .AW    (MEM_AW)
  ) u_mem (
    .clk_i   (CLK),
    .rst_i   (RST),
    .we_i    (mem_we),
    .addr_i  (addr_q[MEM_AW-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  assign bus.PREADY = done;
  assign bus.PRDATA = (done & ~wr_q & in_range) ? mem_rdata : '0;

`ifdef APB_SLAVE_ERR_EN
  assign bus.PSLVERR = done & ~in_range;
`else
  assign bus.PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave.sv
// Scoreboard bench: two slaves (WAIT_CYCLES=2 and 0) behind one muxed master.
module tb_apb_slave;
  import apb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  apb_slave_if bus_a ();
  apb_slave_if bus_b ();

  apb_slave #(.DEPTH(64), .WAIT_CYCLES(2)) dut_a (.CLK(clk), .RST(rst), .bus(bus_a));
  apb_slave #(.DEPTH(64), .WAIT_CYCLES(0)) dut_b (.CLK(clk), .RST(rst), .bus(bus_b));

  logic       sel;
  logic       m_psel, m_pen, m_pwrite;
  logic [8:0] m_paddr;
  logic [7:0] m_pwdata;

  assign bus_a.PSEL   = m_psel & ~sel;
  assign bus_a.PEN    = m_pen;
  assign bus_a.PWRITE = m_pwrite;
  assign bus_a.PADDR  = m_paddr;
  assign bus_a.PWDATA = m_pwdata;
  assign bus_b.PSEL   = m_psel & sel;
  assign bus_b.PEN    = m_pen;
  assign bus_b.PWRITE = m_pwrite;
  assign bus_b.PADDR  = m_paddr;
  assign bus_b.PWDATA = m_pwdata;

  wire       r_pready  = sel ? bus_b.PREADY  : bus_a.PREADY;
  wire       r_pslverr = sel ? bus_b.PSLVERR : bus_a.PSLVERR;
  wire [7:0] r_prdata  = sel ? bus_b.PRDATA  : bus_a.PRDATA;

`ifdef APB_SLAVE_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  typedef struct {
    bit         is_read;
    logic [7:0] rdata;
    bit         err;
    int         waits;
    int         tag;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   low_cnt = 0;
  int   tag_n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per PREADY pulse.
  initial begin : monitor
    exp_t me;
    forever begin
      @(negedge clk);
      if (rst || !m_psel) low_cnt = 0;
      else if (m_pen && !r_pready) low_cnt++;
      if (!rst) begin
        if (r_pready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pready: got PREADY=1 expected no completion (sel=%0d)", sel);
          end else begin
            me = exp_q.pop_front();
            check($sformatf("wait_cycles tag%0d", me.tag), low_cnt, me.waits);
            check($sformatf("pslverr tag%0d", me.tag), r_pslverr, me.err);
            if (me.is_read) check($sformatf("prdata tag%0d", me.tag), r_prdata, me.rdata);
          end
          low_cnt = 0;
        end else begin
          check("prdata_idle", r_prdata, 8'h00);
          check("pslverr_idle", r_pslverr, 1'b0);
        end
      end
    end
  end

  task automatic xfer(input bit wr, input logic [8:0] a, input logic [7:0] d,
                      input logic [7:0] exp_rd, input bit exp_err);
    exp_t e;
    bit   got;
    e.is_read = !wr;
    e.rdata   = exp_rd;
    e.err     = exp_err;
    e.waits   = sel ? 0 : 2;
    e.tag     = tag_n++;
    @(posedge clk); #1;
    exp_q.push_back(e);
    m_psel = 1'b1; m_pen = 1'b0; m_pwrite = wr; m_paddr = a; m_pwdata = d;
    @(posedge clk); #1;
    m_pen = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = r_pready;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout tag%0d: got no PREADY expected PREADY within 40 cycles", e.tag);
      exp_q.delete();
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    m_psel = 1'b0; m_pen = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got no finish expected finish before 300us");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    sel = 1'b0; m_psel = 1'b0; m_pen = 1'b0; m_pwrite = 1'b0;
    m_paddr = '0; m_pwdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_pready_a",  bus_a.PREADY,  1'b0);
    check("rst_pslverr_a", bus_a.PSLVERR, 1'b0);
    check("rst_prdata_a",  bus_a.PRDATA,  8'h00);
    check("rst_pready_b",  bus_b.PREADY,  1'b0);
    check("rst_pslverr_b", bus_b.PSLVERR, 1'b0);
    check("rst_prdata_b",  bus_b.PRDATA,  8'h00);

    // WAIT_CYCLES=2 slave
    xfer(1, 9'h010, 8'hA5, 8'h00, 1'b0); idle();
    xfer(0, 9'h010, 8'h00, 8'hA5, 1'b0); idle();
    xfer(0, 9'h003, 8'h00, 8'h00, 1'b0); idle();
    xfer(1, 9'h001, 8'h11, 8'h00, 1'b0);
    xfer(1, 9'h002, 8'h22, 8'h00, 1'b0);
    xfer(0, 9'h001, 8'h00, 8'h11, 1'b0);
    xfer(0, 9'h002, 8'h00, 8'h22, 1'b0); idle();
    xfer(1, 9'h03F, 8'hC3, 8'h00, 1'b0);
    xfer(0, 9'h03F, 8'h00, 8'hC3, 1'b0);
    xfer(1, 9'h040, 8'h99, 8'h00, ERR_ON);
    xfer(0, 9'h040, 8'h00, 8'h00, ERR_ON);
    xfer(1, 9'h050, 8'h77, 8'h00, ERR_ON);
    xfer(0, 9'h050, 8'h00, 8'h00, ERR_ON);
    xfer(1, 9'h120, 8'h5A, 8'h00, 1'b0);
    xfer(0, 9'h020, 8'h00, 8'h5A, 1'b0); idle();

    // abort by dropping PSEL in WAIT
    @(posedge clk); #1;
    m_psel = 1'b1; m_pen = 1'b0; m_pwrite = 1'b1; m_paddr = 9'h005; m_pwdata = 8'h3C;
    @(posedge clk); #1 m_pen = 1'b1;
    @(posedge clk); #1 m_psel = 1'b0; m_pen = 1'b0;
    repeat (3) @(posedge clk);
    xfer(0, 9'h005, 8'h00, 8'h00, 1'b0); idle();

    // reset pulse during WAIT, then PSEL&PEN held in IDLE without setup
    @(posedge clk); #1;
    m_psel = 1'b1; m_pen = 1'b0; m_pwrite = 1'b1; m_paddr = 9'h010; m_pwdata = 8'hEE;
    @(posedge clk); #1 m_pen = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_abort_pready", r_pready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("no_setup_pready", r_pready, 1'b0);
    idle();
    xfer(0, 9'h010, 8'h00, 8'h00, 1'b0);
    xfer(0, 9'h001, 8'h00, 8'h00, 1'b0);
    xfer(1, 9'h010, 8'h4D, 8'h00, 1'b0);
    xfer(0, 9'h010, 8'h00, 8'h4D, 1'b0); idle();

    // WAIT_CYCLES=0 slave
    @(posedge clk); #1 sel = 1'b1;
    xfer(0, 9'h003, 8'h00, 8'h00, 1'b0); idle();
    xfer(1, 9'h007, 8'h81, 8'h00, 1'b0);
    xfer(0, 9'h007, 8'h00, 8'h81, 1'b0);
    xfer(0, 9'h010, 8'h00, 8'h00, 1'b0);
    xfer(1, 9'h0FF, 8'h12, 8'h00, ERR_ON);
    xfer(0, 9'h0FF, 8'h00, 8'h00, ERR_ON);
    xfer(1, 9'h13E, 8'h6B, 8'h00, 1'b0);
    xfer(0, 9'h03E, 8'h00, 8'h6B, 1'b0); idle();

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_slave.md
APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 8-bit storage locations (1..256).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, PREADY-low cycles inserted per access (0..15).
REQ-003 SHALL have port CLK  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port PSEL  input  1  slave select from master (PSEL1 or PSEL2 of the master).
REQ-006 SHALL have port PEN  input  1  APB enable; high in access phase.
REQ-007 SHALL have port PWRITE  input  1  1 = write, 0 = read.
REQ-008 SHALL have port PADDR  input  9  byte address; bits [7:0] index storage; bit 8 ignored.
REQ-009 SHALL have port PWDATA  input  8  write data.
REQ-010 SHALL have port PRDATA  output  8  read data.
REQ-011 SHALL have port PREADY  output  1  transfer completion.
REQ-012 SHALL have port PSLVERR  output  1  transfer error, valid only while PREADY high.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, DONE.
REQ-014 IDLE: on PSEL=1 & PEN=0 (setup) SHALL latch PADDR[7:0], PWRITE, PWDATA, clear wait counter, go WAIT.
REQ-015 WAIT: PREADY=0; SHALL increment 4-bit wait counter each cycle PSEL&PEN=1; when counter == WAIT_CYCLES go DONE.
REQ-016 WAIT_CYCLES=0: SHALL assert PREADY in the first access cycle (setup -> DONE directly, PREADY combinational from state DONE).
REQ-017 DONE: PREADY=1 for exactly one cycle; SHALL then go IDLE, or WAIT if PSEL=1 & PEN=0 that cycle is impossible by protocol, so always IDLE.
REQ-018 Write SHALL update storage at the clock edge ending the DONE cycle, using latched address/data.
REQ-019 Read: PRDATA SHALL present storage[latched address] during DONE; PRDATA SHALL be 8'h00 outside DONE.
REQ-020 Back-to-back transfers SHALL be supported: master setup in the cycle after DONE is accepted from IDLE with no bubble.
REQ-021 PSEL deasserted while in WAIT SHALL abort: go IDLE, no write, PREADY stays 0.
REQ-022 PEN=1 with PSEL=1 while in IDLE (missing setup) SHALL be ignored; state stays IDLE.
REQ-023 Read of a location never written SHALL return 8'h00 (post-reset content).
REQ-024 Address >= DEPTH: write SHALL be discarded, read SHALL return 8'h00.

Reset
REQ-025 RST=1 at a rising edge SHALL force state IDLE, wait counter 0, PREADY=0, PSLVERR=0, PRDATA=8'h00, all storage 8'h00.
REQ-026 RST asserted mid-transfer SHALL abort it with no storage update; first transfer after RST release is a normal setup from IDLE.

Configuration
REQ-027 Macro APB_SLAVE_ERR_EN defined: PSLVERR=1 during DONE when latched address >= DEPTH; otherwise 0.
REQ-028 Macro APB_SLAVE_ERR_EN undefined: PSLVERR SHALL be tied 0; out-of-range behaviour per REQ-024 unchanged.

Structure
REQ-029 Package apb_pkg SHALL hold the FSM state enum, APB_ADDR_W=9, APB_DATA_W=8, and wait-counter width 4.
REQ-030 Storage SHALL be sub-module apb_slave_mem (DEPTH x 8, synchronous write, asynchronous read, synchronous clear on RST).

Verification
REQ-031 Write 8'hA5 to addr 9'h010, WAIT_CYCLES=2 -> PREADY low 2 access cycles, high 1; read 9'h010 returns 8'hA5 in DONE.
REQ-032 WAIT_CYCLES=0, read addr 9'h003 after reset -> PREADY=1 in first access cycle, PRDATA=8'h00.
REQ-033 Write addr 9'h050 (DEPTH=64) with APB_SLAVE_ERR_EN -> PSLVERR=1 with PREADY; read back 8'h00; without macro PSLVERR=0.
REQ-034 PSEL dropped in WAIT during write of 8'h3C to 9'h005 -> no PREADY, read of 9'h005 returns 8'h00.
REQ-035 RST pulsed one cycle in WAIT of a write -> state IDLE, PREADY=0, target location unchanged; next write/read completes normally.
REQ-036 Back-to-back writes 8'h11 @9'h001, 8'h22 @9'h002 with no idle cycle -> both complete, readback 8'h11, 8'h22.
